branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Fetch-side next-PC predictor that produces the predicted next PC consumed by the PC register each fetch cycle. It is a direct-mapped branch target buffer with one 2-bit saturating counter per entry. The block is trained by branch resolution feedback from the execute stage. It also generates the mispredict flag (error) and the recovery PC (new_pc) that the PC register uses to restore the correct fetch stream.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 2..256.
INDEX_W, 4, log2(ENTRIES); index = pc[INDEX_W-1:0], tag = pc[15:INDEX_W].
PC_STEP, 1, sequential PC increment in instruction-address units.

Ports:
clk  in  1  clock; table updates on posedge.
rst  in  1  reset, asynchronous, active-high.
pc  in  16  current fetch PC (lookup address).
pre_pc  out  16  predicted next PC (combinational).
pred_taken  out  1  lookup hit and counter[1]==1.
upd_valid  in  1  execute stage presents a resolved instruction this cycle.
upd_is_branch  in  1  resolved instruction is a branch/jump.
upd_pc  in  16  PC of the resolved instruction.
upd_taken  in  1  actual direction.
upd_target  in  16  actual taken target.
upd_pred_next  in  16  pre_pc that was predicted for upd_pc, carried down the pipe.
error  out  1  mispredict (combinational).
new_pc  out  16  correct next PC for upd_pc (combinational).
branch_cnt  out  16  resolved-branch count (optional feature).
miss_cnt  out  16  mispredict count (optional feature).

Behaviour:
- Entry fields: valid, tag[15-INDEX_W:0], target[15:0], ctr[1:0].
- Reset, asynchronous: all valid=0; all ctr=2'b01; tag and target=0. pre_pc=pc+PC_STEP, pred_taken=0, error=0, new_pc=upd_pc+PC_STEP. Reset mid-operation discards any pending update.
- Lookup, purely combinational:
  - hit = valid[idx] && tag[idx]==pc[15:INDEX_W].
  - pred_taken = hit && ctr[idx][1].
  - pre_pc = pred_taken ? target[idx] : pc+PC_STEP.
- All additions are 16-bit modulo, so 16'hFFFF+1 wraps to 16'h0000.
- Resolution, combinational:
  - actual = upd_taken ? upd_target : upd_pc+PC_STEP.
  - new_pc = actual.
  - error = upd_valid && (actual != upd_pred_next).
  - When upd_valid=0, error=0.
- Training, on posedge clk, only when upd_valid=1 (uhit = tag/valid match at upd_pc's index):
  - is_branch, uhit: ctr saturating +1 if taken (max 2'b11), -1 if not taken (min 2'b00). If taken, target<=upd_target.
  - is_branch, !uhit, taken: allocate or overwrite the entry: valid=1, tag, target=upd_target, ctr=2'b10.
  - is_branch, !uhit, not taken: no change.
  - !is_branch, uhit: valid<=0 (alias purge).
  - !is_branch, !uhit: no change.
- Simultaneous lookup and update at the same index: the lookup sees pre-update contents; the new contents are visible from the cycle after the posedge.
- Latency: prediction 0 cycles; training visible 1 cycle after the update edge.
- No stall input. When the PC register holds pc, the lookup result is stable unless training changes the entry.

Optional Feature:
BP_STATS_EN:
- With BP_STATS_EN defined:
  - branch_cnt increments on each posedge with upd_valid && upd_is_branch.
  - miss_cnt increments on each posedge with error=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Without BP_STATS_EN: branch_cnt and miss_cnt are tied to 16'h0000 and no counter flops are built.

Test Plan:
1. Cold lookup: rst pulse, pc=16'h0010 -> pre_pc=16'h0011, pred_taken=0.
2. Allocate then predict: update upd_pc=16'h0010, taken, target=16'h0040, upd_pred_next=16'h0011 -> error=1, new_pc=16'h0040. Next cycle pc=16'h0010 -> pred_taken=1, pre_pc=16'h0040.
3. Counter hysteresis: from ctr=2'b10, one not-taken update -> ctr=01, pre_pc=pc+1. Two taken updates -> ctr=11. One not-taken update -> still predicts 16'h0040.
4. Correct prediction: upd_taken=1, upd_target=16'h0040, upd_pred_next=16'h0040 -> error=0. Alias: pc=16'h0020 (same index, different tag) -> miss, pre_pc=16'h0021.
5. Alias purge plus same-cycle read: non-branch update at 16'h0010 while pc=16'h0010 -> that cycle pre_pc=16'h0040; next cycle pre_pc=16'h0011.
6. Wrap and async reset: pc=16'hFFFF -> pre_pc=16'h0000. Assert rst between edges with trained entries -> pred_taken=0 immediately. With BP_STATS_EN, branch_cnt and miss_cnt read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side next-PC predictor. A direct-mapped branch target buffer (BTB)
// holds one entry per index, each entry carrying a valid bit, a tag, a taken
// target and a 2-bit saturating direction counter. The fetch PC is looked up
// combinationally every cycle to produce the predicted next PC. Resolved
// instructions coming back from execute train the table on the rising clock
// edge. The same feedback also drives the mispredict flag and the recovery PC
// used by the PC register.
//
// Parameters
//   ENTRIES  number of BTB entries (power of two, 2..256)
//   INDEX_W  log2(ENTRIES); index = pc[INDEX_W-1:0], tag = pc[15:INDEX_W]
//   PC_STEP  sequential PC increment in instruction-address units
//
// Ports
//   clk            in   clock; table and statistics update on posedge
//   rst            in   asynchronous, active-high reset
//   pc             in   current fetch PC (lookup address)
//   pre_pc         out  predicted next PC (combinational)
//   pred_taken     out  lookup hit and counter predicts taken
//   upd_valid      in   a resolved instruction is presented this cycle
//   upd_is_branch  in   resolved instruction is a branch/jump
//   upd_pc         in   PC of the resolved instruction
//   upd_taken      in   actual direction
//   upd_target     in   actual taken target
//   upd_pred_next  in   pre_pc that was predicted for upd_pc
//   error          out  mispredict flag (combinational)
//   new_pc         out  correct next PC for upd_pc (combinational)
//   branch_cnt     out  resolved-branch count (statistics build only)
//   miss_cnt       out  mispredict count (statistics build only)
//
// Build option
//   BP_STATS_EN    when defined, builds saturating 16-bit branch and
//                  mispredict counters; otherwise both outputs read 16'h0000
//                  and no counter flops exist.
//
// Update interface handshake: upd_valid is a one-way valid with no ready.
// The predictor always accepts a presented resolution; it is consumed on the
// posedge where upd_valid=1, and error/new_pc describe it combinationally in
// that same cycle. There is no backpressure and no stall.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4,
    parameter int PC_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    output logic [15:0] pre_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic        upd_is_branch,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    input  logic [15:0] upd_pred_next,
    output logic        error,
    output logic [15:0] new_pc,
    output logic [15:0] branch_cnt,
    output logic [15:0] miss_cnt
);

    localparam int          TAG_W = 16 - INDEX_W;
    localparam logic [15:0] STEP  = 16'(PC_STEP);

    // Counter value given to a freshly allocated entry: weakly taken.
    localparam logic [1:0]  CTR_ALLOC = 2'b10;
    // Counter value after reset: weakly not-taken.
    localparam logic [1:0]  CTR_RESET = 2'b01;

    // -----------------------------------------------------------------------
    // BTB storage
    // -----------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [15:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // -----------------------------------------------------------------------
    // Lookup (fetch side), purely combinational
    // -----------------------------------------------------------------------
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic [15:0]        lk_seq;

    assign lk_idx = pc[INDEX_W-1:0];
    assign lk_tag = pc[15:INDEX_W];
    assign lk_seq = pc + STEP;  // 16-bit modulo: 16'hFFFF wraps to 16'h0000

    assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken = lk_hit && ctr_q[lk_idx][1];

    // The table is read before any same-cycle training lands, so a lookup
    // at the index being trained still sees the old contents this cycle.
    assign pre_pc = pred_taken ? target_q[lk_idx] : lk_seq;

    // -----------------------------------------------------------------------
    // Resolution (execute side), combinational
    // -----------------------------------------------------------------------
    logic [15:0] up_seq;
    logic [15:0] up_actual;

    assign up_seq    = upd_pc + STEP;
    assign up_actual = upd_taken ? upd_target : up_seq;

    // While reset is held the recovery path reports the sequential successor
    // and never flags a mispredict, whatever execute is presenting.
    assign new_pc = rst ? up_seq : up_actual;
    assign error  = !rst && upd_valid && (up_actual != upd_pred_next);

    // -----------------------------------------------------------------------
    // Training decode
    // -----------------------------------------------------------------------
    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic [1:0]         up_ctr;
    logic [1:0]         up_ctr_inc;
    logic [1:0]         up_ctr_dec;

    assign up_idx = upd_pc[INDEX_W-1:0];
    assign up_tag = upd_pc[15:INDEX_W];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr = ctr_q[up_idx];

    // Saturating counter steps: hold at 2'b11 going up, at 2'b00 going down.
    assign up_ctr_inc = (up_ctr == 2'b11) ? up_ctr : up_ctr + 2'd1;
    assign up_ctr_dec = (up_ctr == 2'b00) ? up_ctr : up_ctr - 2'd1;

    logic       wr_alloc;   // install or overwrite the entry at up_idx
    logic       wr_ctr;     // update the direction counter of a hit entry
    logic       wr_target;  // refresh the target of a hit entry
    logic       wr_purge;   // invalidate a hit entry (non-branch alias)
    logic [1:0] ctr_nxt;

    always_comb begin
        wr_alloc  = 1'b0;
        wr_ctr    = 1'b0;
        wr_target = 1'b0;
        wr_purge  = 1'b0;
        ctr_nxt   = up_ctr;
        if (upd_valid) begin
            if (upd_is_branch) begin
                if (up_hit) begin
                    wr_ctr    = 1'b1;
                    ctr_nxt   = upd_taken ? up_ctr_inc : up_ctr_dec;
                    wr_target = upd_taken;
                end else if (upd_taken) begin
                    // Not-taken misses are not allocated: a sequential
                    // prediction is already correct for them.
                    wr_alloc = 1'b1;
                end
            end else if (up_hit) begin
                // A non-branch sits at a PC the BTB believes is a branch
                // (tag alias or self-modifying code); drop the entry so
                // fetch stops redirecting there.
                wr_purge = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Table state. Async reset clears every entry, which also discards any
    // update being presented while reset is asserted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            if (wr_alloc) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_ALLOC;
            end
            if (wr_ctr) begin
                ctr_q[up_idx] <= ctr_nxt;
            end
            if (wr_target) begin
                target_q[up_idx] <= upd_target;
            end
            if (wr_purge) begin
                valid_q[up_idx] <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (upd_valid && upd_is_branch && (branch_cnt_q != 16'hFFFF)) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (error && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;
`else
    assign branch_cnt = 16'h0000;
    assign miss_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor (default parameters: 16 entries,
// 4 index bits, PC step 1). A behavioural model of the BTB (per-index valid,
// tag, target and an integer direction count 0..3) predicts every output;
// one compare process checks all DUT outputs on each falling edge. Directed
// steps with hand-computed literals pin the model, then randomized traffic
// with occasional mid-cycle async resets runs against it.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] pre_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic        upd_is_branch;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [15:0] upd_pred_next;
    logic        error;
    logic [15:0] new_pc;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    int total;
    int bad;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pre_pc        (pre_pc),
        .pred_taken    (pred_taken),
        .upd_valid     (upd_valid),
        .upd_is_branch (upd_is_branch),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred_next (upd_pred_next),
        .error         (error),
        .new_pc        (new_pc),
        .branch_cnt    (branch_cnt),
        .miss_cnt      (miss_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid  [16];
    logic [11:0] m_tag    [16];
    logic [15:0] m_target [16];
    int          m_ctr    [16];
    int          m_branch;
    int          m_miss;

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_branch = 0;
        m_miss   = 0;
    endfunction

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[3:0]] && (m_tag[a[3:0]] == a[15:4]);
    endfunction

    function automatic bit m_taken(input logic [15:0] a);
        return m_hit(a) && (m_ctr[a[3:0]] >= 2);
    endfunction

    function automatic logic [15:0] m_pre(input logic [15:0] a);
        return m_taken(a) ? m_target[a[3:0]] : a + 16'd1;
    endfunction

    function automatic logic [15:0] m_actual();
        return upd_taken ? upd_target : upd_pc + 16'd1;
    endfunction

    // Applies the resolution presented during the cycle that just ended.
    function automatic void model_train();
        int k;
        k = int'(upd_pc[3:0]);
        if (!upd_valid) return;
        if (m_actual() != upd_pred_next && m_miss < 65535) m_miss++;
        if (upd_is_branch) begin
            if (m_branch < 65535) m_branch++;
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[k]    = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                    m_target[k] = upd_target;
                end else begin
                    m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                end
            end else if (upd_taken) begin
                m_valid[k]  = 1'b1;
                m_tag[k]    = upd_pc[15:4];
                m_target[k] = upd_target;
                m_ctr[k]    = 2;
            end
        end else if (m_hit(upd_pc)) begin
            m_valid[k] = 1'b0;
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: all outputs against the model.
    initial begin
        logic [15:0] exp_cnt_b;
        logic [15:0] exp_cnt_m;
        forever begin
            @(negedge clk);
            check16("pre_pc", pre_pc, m_pre(pc));
            check1("pred_taken", pred_taken, m_taken(pc));
            check1("error", error, !rst && upd_valid && (m_actual() != upd_pred_next));
            check16("new_pc", new_pc, rst ? upd_pc + 16'd1 : m_actual());
`ifdef BP_STATS_EN
            exp_cnt_b = 16'(m_branch);
            exp_cnt_m = 16'(m_miss);
`else
            exp_cnt_b = 16'h0000;
            exp_cnt_m = 16'h0000;
`endif
            check16("branch_cnt", branch_cnt, exp_cnt_b);
            check16("miss_cnt", miss_cnt, exp_cnt_m);
        end
    end

    // ---------------- driver tasks ----------------
    // Trains the model on the inputs that were stable across the edge, then
    // applies new inputs 1 time unit later; returns 2 units after the edge.
    task automatic drive(input logic [15:0] p, input logic uv, input logic ub,
                         input logic [15:0] upc, input logic ut,
                         input logic [15:0] utgt, input logic [15:0] upn);
        @(posedge clk);
        if (!rst) model_train();
        #1;
        pc            = p;
        upd_valid     = uv;
        upd_is_branch = ub;
        upd_pc        = upc;
        upd_taken     = ut;
        upd_target    = utgt;
        upd_pred_next = upn;
        #1;
    endtask

    task automatic idle(input logic [15:0] p);
        drive(p, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic lit_lookup(input string name, input logic [15:0] exp_pre, input logic exp_tk);
        check16({name, ".pre_pc"}, pre_pc, exp_pre);
        check1({name, ".pred_taken"}, pred_taken, exp_tk);
    endtask

    task automatic lit_res(input string name, input logic exp_err, input logic [15:0] exp_new);
        check1({name, ".error"}, error, exp_err);
        check16({name, ".new_pc"}, new_pc, exp_new);
    endtask

    // Asserts reset between edges, holds it across one posedge, releases it
    // between edges.
    task automatic mid_reset(input bit literal);
        rst = 1'b1;
        model_clear();
        #1;
        if (literal) begin
            check1("async_rst.pred_taken", pred_taken, 1'b0);
            check16("async_rst.pre_pc", pre_pc, pc + 16'd1);
            check16("async_rst.branch_cnt", branch_cnt, 16'h0000);
            check16("async_rst.miss_cnt", miss_cnt, 16'h0000);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_pc();
        case ($urandom_range(0, 7))
            0:       return 16'hFFF0 | 16'($urandom_range(0, 15));
            1:       return 16'($urandom_range(0, 65535));
            default: return 16'($urandom_range(0, 63));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rp;
        logic [15:0] rupc;
        logic        rut;
        logic [15:0] rtgt;
        logic [15:0] rpn;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        pc = '0; upd_valid = 1'b0; upd_is_branch = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_next = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // 1. cold lookup
        idle(16'h0010);
        lit_lookup("cold", 16'h0011, 1'b0);

        // 2. allocate then predict
        drive(16'h0010, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0040, 16'h0011);
        lit_res("alloc", 1'b1, 16'h0040);
        lit_lookup("alloc_same_cycle", 16'h0011, 1'b0);
        idle(16'h0010);
        lit_lookup("alloc_next", 16'h0040, 1'b1);

        // 3. counter hysteresis (10 -> 01 -> 10 -> 11 -> 10)
        drive(16'h0010, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0040);
        lit_res("nt_update", 1'b1, 16'h0011);
        drive(16'h0010, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0040, 16'h0011);
        lit_lookup("ctr01", 16'h0011, 1'b0);
        drive(16'h0010, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0040, 16'h0040);
        lit_lookup("ctr10", 16'h0040, 1'b1);
        drive(16'h0010, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0040);
        idle(16'h0010);
        lit_lookup("hysteresis", 16'h0040, 1'b1);

        // 4. correct prediction, then alias at the same index
        drive(16'h0010, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h0040, 16'h0040);
        lit_res("correct", 1'b0, 16'h0040);
        idle(16'h0020);
        lit_lookup("alias", 16'h0021, 1'b0);

        // 5. alias purge with same-cycle read
        drive(16'h0010, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0011);
        lit_lookup("purge_same_cycle", 16'h0040, 1'b1);
        lit_res("purge", 1'b0, 16'h0011);
        idle(16'h0010);
        lit_lookup("purge_next", 16'h0011, 1'b0);

        // 6. wrap and async reset with a trained entry
        idle(16'hFFFF);
        lit_lookup("wrap", 16'h0000, 1'b0);
        drive(16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h1234, 16'h0000);
        lit_res("wrap_res", 1'b0, 16'h0000);
        drive(16'h0030, 1'b1, 1'b1, 16'h0030, 1'b1, 16'h0100, 16'h0031);
        idle(16'h0030);
        lit_lookup("trained", 16'h0100, 1'b1);
        mid_reset(1'b1);
        idle(16'h0030);
        lit_lookup("after_rst", 16'h0031, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rp   = rand_pc();
            rupc = rand_pc();
            rut  = 1'($urandom_range(0, 1));
            rtgt = ($urandom_range(0, 1) == 1) ? rand_pc() : 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0, 1:    rpn = m_pre(rupc);
                2:       rpn = rut ? rtgt : rupc + 16'd1;
                default: rpn = 16'($urandom_range(0, 65535));
            endcase
            drive(rp, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  rupc, rut, rtgt, rpn);
            if ($urandom_range(0, 499) == 0) mid_reset(1'b0);
        end

        idle(16'h0000);
        @(posedge clk);
        #6;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
